mips_mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-ported synchronous memory between the instruction-fetch port (port 0) and the data load/store port (port 1) of the multicycle MIPS core. It accepts one transaction at a time and sequences it through issue, read-latency wait and completion. It returns read data and a per-port done pulse, so the core can run from a single memory macro instead of a dual-ported one.

---
 rtl/mips_mem_arbiter_pkg.sv | 24 ++
 rtl/mips_mem_arbiter_rr_arbiter2.sv | 18 +
 rtl/mips_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// rtl/mips_mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
package mips_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int ARB_PORT_IF   = 0;
    localparam int ARB_PORT_DATA = 1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Wait-counter preload; out-of-range latencies are clamped into the legal window.
    function automatic logic [1:0] wait_load(input int lat);
        int l;
        l = (lat < RD_LAT_MIN) ? RD_LAT_MIN : ((lat > RD_LAT_MAX) ? RD_LAT_MAX : lat);
        return 2'(l - 1);
    endfunction

endpackage

// File: rtl/mips_mem_arbiter_rr_arbiter2.sv
// rtl/mips_mem_arbiter_rr_arbiter2.sv - combinational two-way round-robin pick
module rr_arbiter2 (
    input  logic [1:0] eligible,
    input  logic       last_owner,
    output logic       win,
    output logic       winner
);

    always_comb begin
        win = |eligible;
        if (&eligible) begin
            winner = ~last_owner;
        end else begin
            winner = eligible[1];
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - shares one synchronous memory between the fetch and load/store ports
module mips_mem_arbiter
    import mips_mem_arbiter_pkg::*;
#(
    parameter int N      = 32,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [N-1:0]  wdata0,
    input  logic [N-1:0]  wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [N-1:0]  rsp_rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata
);

    localparam logic [1:0] LAT_LOAD = wait_load(RD_LAT);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          owner_q;
    logic          last_owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [N-1:0]  wdata_q;
    logic [1:0]    cnt_q;
    logic [1:0]    eligible;
    logic          win;
    logic          winner;
    logic          take;

    rr_arbiter2 u_rr (
        .eligible   (eligible),
        .last_owner (last_owner_q),
        .win        (win),
        .winner     (winner)
    );

    // The finishing owner is masked in DONE so a re-request must pass through IDLE or a foreign grant.
    always_comb begin
        eligible = {req1, req0};
        if (state_q == ST_DONE) begin
            eligible[owner_q] = 1'b0;
        end
        take    = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win) begin
                    take    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = we_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (win) begin
                    take    = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'(ARB_PORT_DATA);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 2'd0;
            rsp_rdata    <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                owner_q      <= winner;
                last_owner_q <= winner;
                we_q         <= winner ? we1 : we0;
                addr_q       <= winner ? addr1 : addr0;
                wdata_q      <= winner ? wdata1 : wdata0;
            end
            if (state_q == ST_ISSUE) begin
                cnt_q <= LAT_LOAD;
            end else if (state_q == ST_WAIT && cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (state_q == ST_WAIT && cnt_q == 2'd0) begin
                rsp_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign gnt0      = mem_en && (owner_q == 1'(ARB_PORT_IF));
    assign gnt1      = mem_en && (owner_q == 1'(ARB_PORT_DATA));
    assign done0     = (state_q == ST_DONE) && (owner_q == 1'(ARB_PORT_IF));
    assign done1     = (state_q == ST_DONE) && (owner_q == 1'(ARB_PORT_DATA));

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - randomized self-checking bench with transaction-level reference model
module tb_mips_mem_arbiter;

    localparam int N      = 32;
    localparam int AW     = 32;
    localparam int RD_LAT = 3;
    localparam int NCYC   = 1500;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          gnt0, gnt1, done0, done1, busy, mem_en, mem_we;
    logic [N-1:0]  rsp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          req_v [2];
    logic          we_v [2];
    logic [31:0]   addr_v [2];
    logic [31:0]   wdata_v [2];
    bit            pend [2];
    bit            granted [2];

    always #5 clk = ~clk;

    mips_mem_arbiter #(.N(N), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .req0      (req_v[0]),
        .req1      (req_v[1]),
        .we0       (we_v[0]),
        .we1       (we_v[1]),
        .addr0     (addr_v[0]),
        .addr1     (addr_v[1]),
        .wdata0    (wdata_v[0]),
        .wdata1    (wdata_v[1]),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h8C01_0004 : (32'hA500_0000 ^ (32'(i) * 32'h0101_0101));
    endfunction

    // Memory macro: 16 words, read data appears RD_LAT cycles after the enable cycle.
    logic [31:0] mem [16];
    bit          written [16];
    logic [31:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[5:2]]     <= mem_wdata;
            written[mem_addr[5:2]] <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            rd_pipe[0] <= written[mem_addr[5:2]] ? mem[mem_addr[5:2]] : init_word(int'(mem_addr[5:2]));
        end else begin
            rd_pipe[0] <= $urandom;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        pend[p]    = 1'b1;
        granted[p] = 1'b0;
        req_v[p]   = 1'b1;
        we_v[p]    = we;
        addr_v[p]  = a;
        wdata_v[p] = d;
    endtask

    task automatic start_txn(input int p);
        logic [31:0] base;
        base = (p == 1) ? 32'h1001_0000 : 32'h0040_0000;
        set_txn(p, 1'($urandom_range(0, 1)), base | (32'($urandom_range(0, 15)) << 2), $urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {gnt1, gnt0}, 2'b00);
        check({tag, "_done"}, {done1, done0}, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_mem_en"}, {mem_en, mem_we}, 2'b00);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    endtask

    // Reference model: one transaction at a time, described by its issue/done cycles.
    bit          m_act, m_own, m_we, m_last;
    int          m_issue, m_done;
    logic [31:0] m_addr, m_wdata, m_rd, e_rdata;
    logic [31:0] ref_mem [16];

    initial begin
        bit       isu, fin, inject, rst_pend;
        bit [1:0] elig;
        bit       w;
        int       n_rst, last_rst;
        logic     s_gnt [2];
        logic     s_done [2];

        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
            pend[p] = 1'b0; granted[p] = 1'b0;
        end
        m_act = 1'b0; m_own = 1'b0; m_we = 1'b0; m_last = 1'b1;
        m_issue = -1; m_done = -1;
        m_addr = '0; m_wdata = '0; m_rd = '0; e_rdata = '0;
        rst_pend = 1'b0; n_rst = 0; last_rst = 0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstb = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (rst_pend) begin
                rstb     = 1'b1;
                rst_pend = 1'b0;
            end

            isu = m_act && (cyc == m_issue);
            fin = m_act && (cyc == m_done);
            if (fin && !m_we) e_rdata = m_rd;
            s_gnt[0] = gnt0; s_gnt[1] = gnt1;
            s_done[0] = done0; s_done[1] = done1;
            check("gnt0", gnt0, isu && !m_own);
            check("gnt1", gnt1, isu && m_own);
            check("done0", done0, fin && !m_own);
            check("done1", done1, fin && m_own);
            check("busy", busy, m_act);
            check("mem_en", mem_en, isu);
            check("mem_we", mem_we, isu && m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("rsp_rdata", rsp_rdata, e_rdata);

            for (int p = 0; p < 2; p++) begin
                if (s_gnt[p] === 1'b1) granted[p] = 1'b1;
                if (s_done[p] === 1'b1) begin
                    pend[p]  = 1'b0;
                    req_v[p] = 1'b0;
                end
            end

            if (cyc == 0) set_txn(0, 1'b0, 32'h0040_0000, 32'h0);
            if (cyc == 10) set_txn(1, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
            if (cyc == 20) begin
                set_txn(0, 1'b0, 32'h0040_0004, 32'h0);
                set_txn(1, 1'b0, 32'h1001_0008, 32'h0);
            end
            if (cyc >= 40) begin
                for (int p = 0; p < 2; p++) begin
                    if (cyc >= 120 && pend[p] && granted[p] && req_v[p] && !we_v[p]
                        && $urandom_range(0, 7) == 0) begin
                        req_v[p] = 1'b0;
                    end
                    if (!pend[p] && (cyc < 120 || $urandom_range(0, 3) == 0)) start_txn(p);
                end
            end

            inject = (cyc >= 150) && (n_rst < 3) && (cyc - last_rst > 50) && m_act && m_own
                     && !m_we && (cyc > m_issue) && (cyc < m_done);
            if (inject) begin
                if (!pend[0]) start_txn(0);
                rstb = 1'b0;
                #1;
                check_all_zero("midrst");
                m_act = 1'b0; m_last = 1'b1; m_addr = '0; m_wdata = '0; e_rdata = '0;
                for (int p = 0; p < 2; p++) begin
                    granted[p] = 1'b0;
                    if (pend[p] && !req_v[p]) pend[p] = 1'b0;
                end
                rst_pend = 1'b1;
                n_rst++;
                last_rst = cyc;
            end else if (!m_act || cyc == m_done) begin
                elig = {req_v[1], req_v[0]};
                if (m_act) elig[m_own] = 1'b0;
                if (elig != 2'b00) begin
                    w       = (elig == 2'b11) ? !m_last : elig[1];
                    m_last  = w;
                    m_act   = 1'b1;
                    m_own   = w;
                    m_we    = we_v[w];
                    m_addr  = addr_v[w];
                    m_wdata = wdata_v[w];
                    m_issue = cyc + 1;
                    m_done  = cyc + 1 + (m_we ? 1 : RD_LAT + 1);
                    if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
                    else      m_rd = ref_mem[m_addr[5:2]];
                end else begin
                    m_act = 1'b0;
                end
            end

            @(negedge clk);
        end

        check("reset_events", 32'(n_rst), 32'd3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
